// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction in flight, data first with a starvation bound.
// Latency: request to o_mem_req 1 cycle, i_mem_rvalid to o_*_rvalid 1 cycle; o_mem_req holds its fields until i_mem_gnt.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  input  logic                i_if_flush,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_d_req,
  input  logic                i_d_we,
  input  logic [ADDR_W-1:0]   i_d_addr,
  input  logic [DATA_W-1:0]   i_d_wdata,
  input  logic [DATA_W/8-1:0] i_d_be,
  output logic                o_d_gnt,
  output logic                o_d_rvalid,
  output logic [DATA_W-1:0]   o_d_rdata,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_be,
  input  logic                i_mem_gnt,
  input  logic                i_mem_rvalid,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

  state_t              state_q;
  logic                owner_d_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BE_W-1:0]     be_q;
  logic [CNT_W-1:0]    starve_q;
  logic                discard_q;
  logic                if_rvalid_q;
  logic                d_rvalid_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;

  logic starve_hit;
  logic sel_data;
  logic flush_hit;

  assign starve_hit = (starve_q == CNT_W'(STARVE_LIMIT));
  assign sel_data   = i_d_req && !(i_if_req && starve_hit);
  assign flush_hit  = i_if_flush && !owner_d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_d_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      starve_q    <= '0;
      discard_q   <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_d_req || i_if_req) begin
            state_q   <= ISSUE;
            owner_d_q <= sel_data;
            discard_q <= 1'b0;
            if (sel_data) begin
              we_q    <= i_d_we;
              addr_q  <= i_d_addr;
              wdata_q <= i_d_wdata;
              be_q    <= i_d_be;
            end else begin
              we_q    <= 1'b0;
              addr_q  <= i_if_addr;
              wdata_q <= '0;
              be_q    <= '1;
            end
            // Count only data wins that actually made a waiting fetch wait.
            if (sel_data && i_if_req) begin
              if (!starve_hit) starve_q <= starve_q + CNT_W'(1);
            end else begin
              starve_q <= '0;
            end
          end
        end
        ISSUE: begin
          if (flush_hit) discard_q <= 1'b1;
          if (i_mem_gnt) state_q <= WAIT_RSP;
        end
        WAIT_RSP: begin
          if (flush_hit) discard_q <= 1'b1;
          if (i_mem_rvalid) begin
            state_q   <= IDLE;
            discard_q <= 1'b0;
            if (owner_d_q) begin
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= i_mem_rdata;
            end else if (!(discard_q || i_if_flush)) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= i_mem_rdata;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_mem_req   = (state_q == ISSUE);
  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_be    = be_q;
  assign o_if_gnt    = o_mem_req && i_mem_gnt && !owner_d_q;
  assign o_d_gnt     = o_mem_req && i_mem_gnt && owner_d_q;
  assign o_if_rvalid = if_rvalid_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_d_rvalid  = d_rvalid_q;
  assign o_d_rdata   = d_rdata_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level model checked every cycle plus literal pins.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_if_req, i_if_flush, o_if_gnt, o_if_rvalid;
  logic [AW-1:0] i_if_addr;
  logic [DW-1:0] o_if_rdata;
  logic          i_d_req, i_d_we, o_d_gnt, o_d_rvalid;
  logic [AW-1:0] i_d_addr;
  logic [DW-1:0] i_d_wdata, o_d_rdata;
  logic [BW-1:0] i_d_be;
  logic          o_mem_req, o_mem_we, i_mem_gnt, i_mem_rvalid, o_busy;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata, i_mem_rdata;
  logic [BW-1:0] o_mem_be;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_flush(i_if_flush),
    .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
    .i_d_be(i_d_be), .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be), .i_mem_gnt(i_mem_gnt),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata), .o_busy(o_busy)
  );

  int vectors = 0;
  int miscomp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscomp++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    vectors++;
    if (act != exp) begin
      miscomp++;
      $display("FAIL %s @%0t: got \"%s\", want \"%s\"", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h100:  return 32'h00500093;
      32'h3000: return 32'h12345678;
      default:  return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // Transaction-level model: one transaction in flight, tracked as "requested / granted".
  bit          m_act = 0, m_gnt = 0, m_own_d = 0, m_disc = 0, m_we = 0, pick_d = 0;
  logic [31:0] m_addr = 0, m_wdata = 0;
  logic [3:0]  m_be = 0;
  int          m_starve = 0;
  bit          m_ifrv = 0, m_drv = 0;
  logic [31:0] m_ifdat = 0, m_ddat = 0;
  bit          exp_req;
  bit          chk_en = 0;

  int          cyc = 0, req_cycles = 0;
  int          if_gnt_cnt = 0, d_gnt_cnt = 0, if_rv_cnt = 0, d_rv_cnt = 0;
  int          last_if_gnt_cyc = 0, last_if_rv_cyc = 0, last_d_rv_cyc = 0;
  bit          if_gnt_seen = 0, d_gnt_seen = 0;
  logic        first_d_we = 0;
  logic [3:0]  first_d_be = 0;
  logic [31:0] first_d_wdata = 0;
  string       seq_s = "";

  initial forever begin
    @(negedge clk);
    cyc++;
    if (chk_en) begin
      exp_req = m_act && !m_gnt;
      chk("mem_req", 32'(o_mem_req), 32'(exp_req));
      chk("busy", 32'(o_busy), 32'(m_act));
      if (exp_req) begin
        chk("mem_addr", o_mem_addr, m_addr);
        chk("mem_we", 32'(o_mem_we), 32'(m_we));
        chk("mem_be", 32'(o_mem_be), 32'(m_be));
        if (m_own_d) chk("mem_wdata", o_mem_wdata, m_wdata);
      end
      chk("if_gnt", 32'(o_if_gnt), 32'(exp_req && i_mem_gnt && !m_own_d));
      chk("d_gnt", 32'(o_d_gnt), 32'(exp_req && i_mem_gnt && m_own_d));
      chk("if_rvalid", 32'(o_if_rvalid), 32'(m_ifrv));
      chk("d_rvalid", 32'(o_d_rvalid), 32'(m_drv));
      chk("if_rdata", o_if_rdata, m_ifdat);
      chk("d_rdata", o_d_rdata, m_ddat);
    end
    if (o_mem_req) req_cycles++;
    if (o_if_gnt) begin
      if_gnt_cnt++; last_if_gnt_cyc = cyc; if_gnt_seen = 1; seq_s = {seq_s, "F"};
    end
    if (o_d_gnt) begin
      if (d_gnt_cnt == 0) begin
        first_d_we = o_mem_we; first_d_be = o_mem_be; first_d_wdata = o_mem_wdata;
      end
      d_gnt_cnt++; d_gnt_seen = 1; seq_s = {seq_s, "D"};
    end
    if (o_if_rvalid) begin if_rv_cnt++; last_if_rv_cyc = cyc; end
    if (o_d_rvalid) begin d_rv_cnt++; last_d_rv_cyc = cyc; end

    // advance the model across the coming edge using this cycle's inputs
    if (rst) begin
      m_act = 0; m_gnt = 0; m_disc = 0; m_starve = 0;
      m_ifrv = 0; m_drv = 0; m_ifdat = 0; m_ddat = 0;
    end else begin
      m_ifrv = 0; m_drv = 0;
      if (!m_act) begin
        if (i_if_req || i_d_req) begin
          pick_d = i_d_req && !(i_if_req && m_starve == SL);
          m_own_d = pick_d; m_act = 1; m_gnt = 0; m_disc = 0;
          if (pick_d) begin
            m_we = i_d_we; m_addr = i_d_addr; m_wdata = i_d_wdata; m_be = i_d_be;
            m_starve = i_if_req ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
          end else begin
            m_we = 0; m_addr = i_if_addr; m_be = 4'hF; m_starve = 0;
          end
        end
      end else begin
        if (i_if_flush && !m_own_d) m_disc = 1;
        if (!m_gnt) begin
          if (i_mem_gnt) m_gnt = 1;
        end else if (i_mem_rvalid) begin
          m_act = 0;
          if (m_own_d) begin m_drv = 1; m_ddat = i_mem_rdata; end
          else if (!m_disc) begin m_ifrv = 1; m_ifdat = i_mem_rdata; end
        end
      end
    end
  end

  // Memory responder
  int          gnt_delay = 0, rsp_delay = 2, gwait = 0, rcnt = 0;
  logic [31:0] rdat_pend = 0;
  initial begin
    i_mem_gnt = 0; i_mem_rvalid = 0; i_mem_rdata = 0;
    forever begin
      @(posedge clk); #1;
      i_mem_gnt = 0; i_mem_rvalid = 0; i_mem_rdata = $urandom;
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin i_mem_rvalid = 1; i_mem_rdata = rdat_pend; end
      end else if (o_mem_req) begin
        if (gwait < gnt_delay) gwait++;
        else begin
          gwait = 0; i_mem_gnt = 1; rcnt = rsp_delay; rdat_pend = mem_rd(o_mem_addr);
        end
      end
    end
  end

  // Requesters drop their request the cycle after being granted
  bit auto_drop = 1;
  initial forever begin
    @(posedge clk); #1;
    if (auto_drop && if_gnt_seen) i_if_req = 0;
    if (auto_drop && d_gnt_seen) i_d_req = 0;
    if_gnt_seen = 0; d_gnt_seen = 0;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin step(1); n++; end while ((o_busy || i_if_req || i_d_req) && n < 200);
    chk({"timeout_", tag}, 32'(n >= 200), 32'd0);
    step(2);
  endtask

  task automatic wait_if_gnt(input string tag);
    int n = 0;
    while (if_gnt_cnt == 0 && n < 100) begin step(1); n++; end
    chk({"gnt_timeout_", tag}, 32'(n >= 100), 32'd0);
  endtask

  task automatic clr_cnt();
    if_gnt_cnt = 0; d_gnt_cnt = 0; if_rv_cnt = 0; d_rv_cnt = 0; req_cycles = 0; seq_s = "";
  endtask

  task automatic fetch(input logic [31:0] a);
    i_if_req = 1; i_if_addr = a;
  endtask

  task automatic data(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    i_d_req = 1; i_d_we = we; i_d_addr = a; i_d_wdata = wd; i_d_be = be;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_mem_req"}, 32'(o_mem_req), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_gnts"}, 32'({o_if_gnt, o_d_gnt}), 0);
    chk({tag, "_rvalids"}, 32'({o_if_rvalid, o_d_rvalid}), 0);
    chk({tag, "_if_rdata"}, o_if_rdata, 0);
    chk({tag, "_d_rdata"}, o_d_rdata, 0);
    chk({tag, "_mem_addr"}, o_mem_addr, 0);
    chk({tag, "_mem_be"}, 32'(o_mem_be), 0);
  endtask

  initial begin
    rst = 1; i_if_req = 0; i_if_addr = 0; i_if_flush = 0;
    i_d_req = 0; i_d_we = 0; i_d_addr = 0; i_d_wdata = 0; i_d_be = 0;
    step(3);
    rst = 0; chk_en = 1;
    chk_zero_outputs("reset");

    // fetch only
    clr_cnt(); rsp_delay = 2;
    fetch(32'h100);
    wait_idle("fetch_only");
    chk("fo_if_gnt_cnt", 32'(if_gnt_cnt), 1);
    chk("fo_if_rv_cnt", 32'(if_rv_cnt), 1);
    chk("fo_if_rdata", o_if_rdata, 32'h00500093);
    chk("fo_latency", 32'(last_if_rv_cyc - last_if_gnt_cyc), 3);
    chk("fo_no_d", 32'(d_gnt_cnt + d_rv_cnt), 0);

    // simultaneous store + fetch
    clr_cnt();
    data(1'b1, 32'h2004, 32'hDEADBEEF, 4'b0011);
    fetch(32'h104);
    wait_idle("simul");
    chk_str("simul_order", seq_s, "DF");
    chk("simul_we", 32'(first_d_we), 1);
    chk("simul_be", 32'(first_d_be), 32'h3);
    chk("simul_wdata", first_d_wdata, 32'hDEADBEEF);
    chk("simul_drv_before_ifgnt", 32'(last_d_rv_cyc < last_if_gnt_cyc), 1);
    chk("simul_if_rdata", o_if_rdata, mem_rd(32'h104));

    // delayed grant
    clr_cnt(); gnt_delay = 3;
    data(1'b0, 32'h3004, 32'h0, 4'hF);
    wait_idle("delayed_gnt");
    chk("dg_req_cycles", 32'(req_cycles), 4);
    chk("dg_gnt_cnt", 32'(d_gnt_cnt), 1);
    gnt_delay = 0;

    // flush in WAIT_RSP, then a normal load
    clr_cnt(); rsp_delay = 2;
    fetch(32'h200);
    wait_if_gnt("flush_wait");
    i_if_flush = 1; step(1); i_if_flush = 0;
    wait_idle("flush_wait");
    data(1'b0, 32'h3000, 32'h0, 4'hF);
    wait_idle("flush_load");
    chk("fl_if_rv_cnt", 32'(if_rv_cnt), 0);
    chk("fl_d_rv_cnt", 32'(d_rv_cnt), 1);
    chk("fl_d_rdata", o_d_rdata, 32'h12345678);
    chk("fl_if_rdata_held", o_if_rdata, mem_rd(32'h104));

    // flush coincident with the response
    clr_cnt(); rsp_delay = 1;
    fetch(32'h204);
    wait_if_gnt("flush_same");
    i_if_flush = 1; step(1); i_if_flush = 0;
    wait_idle("flush_same");
    chk("fs_if_rv_cnt", 32'(if_rv_cnt), 0);

    // flush in IDLE has no effect
    clr_cnt(); rsp_delay = 2;
    fetch(32'h108); i_if_flush = 1; step(1); i_if_flush = 0;
    wait_idle("flush_idle");
    chk("fi_if_rv_cnt", 32'(if_rv_cnt), 1);
    chk("fi_if_rdata", o_if_rdata, mem_rd(32'h108));

    // reset during WAIT_RSP, stray response afterwards
    clr_cnt(); rsp_delay = 3;
    fetch(32'h300);
    wait_if_gnt("rst_wait");
    rst = 1; step(1); rst = 0;
    chk_zero_outputs("midrst");
    step(4);
    chk("mr_if_rv_cnt", 32'(if_rv_cnt), 0);
    chk("mr_busy", 32'(o_busy), 0);
    chk("mr_if_rdata", o_if_rdata, 0);
    rsp_delay = 2;
    fetch(32'h100);
    wait_idle("after_rst");
    chk("ar_if_rv_cnt", 32'(if_rv_cnt), 1);
    chk("ar_if_rdata", o_if_rdata, 32'h00500093);

    // starvation bound with both requesters held
    rst = 1; step(1); rst = 0;
    clr_cnt(); rsp_delay = 1; auto_drop = 0;
    data(1'b0, 32'h4000, 32'h0, 4'hF);
    fetch(32'h400);
    begin
      int n = 0;
      while (seq_s.len() < 10 && n < 400) begin step(1); n++; end
      chk("starve_timeout", 32'(n >= 400), 0);
    end
    i_d_req = 0; i_if_req = 0; auto_drop = 1;
    wait_idle("starve");
    chk_str("starve_seq", (seq_s.len() >= 10) ? seq_s.substr(0, 9) : seq_s, "DDDDFDDDDF");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout @%0t: got hang, want completion", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory port between the instruction-fetch requester and the load/store requester of the pipelined core.
- Single outstanding transaction; fixed priority to data accesses, with a starvation bound that guarantees fetch progress.
- Supports a fetch flush (pipeline redirect) that discards an in-flight fetch response without breaking the memory-side handshake.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- STARVE_LIMIT, 4, max consecutive data selections while i_if_req is pending (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_if_req  in  1  fetch request; held with address stable until o_if_gnt
- i_if_addr  in  ADDR_W  fetch address
- i_if_flush  in  1  discard any accepted-but-unreturned fetch
- o_if_gnt  out  1  one-cycle pulse: fetch accepted by memory
- o_if_rvalid  out  1  one-cycle pulse: fetch data valid
- o_if_rdata  out  DATA_W  fetch data
- i_d_req  in  1  data request; held with all fields stable until o_d_gnt
- i_d_we  in  1  1 = store, 0 = load
- i_d_addr  in  ADDR_W  data address
- i_d_wdata  in  DATA_W  store data
- i_d_be  in  DATA_W/8  byte enables
- o_d_gnt  out  1  one-cycle pulse: data request accepted
- o_d_rvalid  out  1  one-cycle pulse: load data / store ack
- o_d_rdata  out  DATA_W  load data (undefined for stores)
- o_mem_req  out  1  memory request
- o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be  out  1/ADDR_W/DATA_W/DATA_W/8  latched request fields
- i_mem_gnt  in  1  memory accepts request this cycle
- i_mem_rvalid  in  1  response valid (reads and writes), ≥1 cycle after gnt
- i_mem_rdata  in  DATA_W  response data
- o_busy  out  1  state ≠ IDLE

Behaviour:
- FSM states: IDLE, ISSUE, WAIT_RSP.
- IDLE, on any request:
  - Select the owner and latch owner, we, addr, wdata, be (fetch requests latch we=0, be=all ones).
  - Go to ISSUE on the next edge.
- Selection:
  - d_req only → data; if_req only → fetch.
  - Both pending → data, unless starve_cnt == STARVE_LIMIT, in which case fetch.
- starve_cnt:
  - +1 on each data selection while i_if_req = 1.
  - Cleared on a fetch selection, or on a data selection with i_if_req = 0.
  - Saturates at STARVE_LIMIT.
- ISSUE:
  - o_mem_req = 1 with the latched fields, held stable until i_mem_gnt.
  - On i_mem_gnt, pulse the owner's gnt combinationally in that cycle (never both gnts), then go to WAIT_RSP.
- WAIT_RSP:
  - On i_mem_rvalid, register i_mem_rdata into the owner's rdata and pulse the owner's rvalid on the next cycle; go to IDLE on the same edge.
  - Latency: req seen at cycle 0 → o_mem_req at cycle 1; rvalid at cycle k → o_*_rvalid at k+1.
  - Next o_mem_req no earlier than k+2.
- Flush:
  - i_if_flush while owner = fetch in ISSUE or WAIT_RSP sets a discard flag.
  - The request still completes its gnt/rvalid handshake, but o_if_rvalid is suppressed. The flag clears on returning to IDLE.
  - Flush in IDLE, or while owner = data, has no effect.
  - Flush in the same cycle as i_mem_rvalid suppresses that response.
- Unowned responses: i_mem_rvalid in IDLE or ISSUE is ignored; no output changes.
- Inputs: i_*_req dropped before gnt is a protocol violation; the latched values are used regardless.
- Reset:
  - state = IDLE; starve_cnt = 0; discard = 0.
  - All outputs 0, including o_mem_req, rdata and gnt/rvalid pulses.
  - Reset mid-transaction abandons it; any later stray rvalid is ignored per the unowned-response rule.
- Rdata outputs hold their value between rvalid pulses.

Test Plan:
- Fetch only: if_req, addr 0x100; gnt in first ISSUE cycle; rvalid 2 cycles later with 0x00500093 → o_if_gnt pulse once; o_if_rvalid/o_if_rdata = 0x00500093 one cycle later; no o_d_* activity.
- Simultaneous: d_req store 0x2004, wdata 0xDEADBEEF, be 4'b0011, plus if_req 0x104 → memory sees the store first (we = 1, be = 0011), then the fetch; o_d_rvalid precedes o_if_gnt.
- Starvation: d_req and if_req held continuously, STARVE_LIMIT = 4 → memory sequence D,D,D,D,F,D,D,D,D,F.
- Delayed gnt: i_mem_gnt low 3 cycles in ISSUE → o_mem_addr/we/wdata/be stable for all 4 cycles; exactly one gnt pulse.
- Flush: i_if_flush during WAIT_RSP of fetch 0x200 → no o_if_rvalid; a following d_req load 0x3000 returning 0x12345678 completes normally.
- Reset in WAIT_RSP, then stray i_mem_rvalid → all outputs 0, state IDLE, o_busy = 0; the next request is served normally.
